// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 pass sequencer: FSM state
// encoding, S-port owner (phase) encoding, key width and the default
// watchdog limit.
package arc4_pkg;

    localparam int KEY_W = 24;
    localparam int unsigned WDOG_CYCLES_DEFAULT = 4096;

    typedef enum logic [3:0] {
        IDLE,
        INIT_GO,
        INIT_SYNC,
        INIT_WAIT,
        KSA_GO,
        KSA_SYNC,
        KSA_WAIT,
        PRGA_GO,
        PRGA_SYNC,
        PRGA_WAIT,
        ERR
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    // Which engine owns the S port in a given state; IDLE and ERR own nothing.
    function automatic phase_t state_phase(input ctrl_state_t s);
        case (s)
            INIT_GO, INIT_SYNC, INIT_WAIT: return PH_INIT;
            KSA_GO,  KSA_SYNC,  KSA_WAIT:  return PH_KSA;
            PRGA_GO, PRGA_SYNC, PRGA_WAIT: return PH_PRGA;
            default:                       return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/arc4_ctrl_if.sv
// Caller-facing handshake of the ARC4 sequencer: start request, ready,
// key, current S-port owner and watchdog error.
interface arc4_ctrl_if;
    import arc4_pkg::*;

    logic             en;
    logic             rdy;
    logic [KEY_W-1:0] key;
    phase_t           phase;
    logic             err;

    // Caller side
    modport master (output en, output key, input rdy, input phase, input err);
    // Sequencer side
    modport slave  (input en, input key, output rdy, output phase, output err);

endinterface

// File: rtl/arc4_s_mux.sv
// Combinational 3:1 mux granting the single S RAM port to the engine
// named by phase. Nothing is forwarded while no engine owns the port.
module arc4_s_mux
    import arc4_pkg::*;
(
    input  phase_t     phase,
    input  logic [7:0] init_s_addr,
    input  logic [7:0] init_s_wrdata,
    input  logic       init_s_wren,
    input  logic [7:0] ksa_s_addr,
    input  logic [7:0] ksa_s_wrdata,
    input  logic       ksa_s_wren,
    input  logic [7:0] prga_s_addr,
    input  logic [7:0] prga_s_wrdata,
    input  logic       prga_s_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren
);

    // Select the owning engine's request; idle port reads as all zeros.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (phase)
            PH_INIT: begin
                s_addr   = init_s_addr;
                s_wrdata = init_s_wrdata;
                s_wren   = init_s_wren;
            end
            PH_KSA: begin
                s_addr   = ksa_s_addr;
                s_wrdata = ksa_s_wrdata;
                s_wren   = ksa_s_wren;
            end
            PH_PRGA: begin
                s_addr   = prga_s_addr;
                s_wrdata = prga_s_wrdata;
                s_wren   = prga_s_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_ctrl.sv
// ARC4 decryption pass sequencer: on an accepted start it runs the init,
// KSA and PRGA engines in turn through their en/rdy handshakes and grants
// the S RAM port to whichever engine is active.
// Optional feature: define ARC4_CTRL_WDOG_EN to add a per-engine busy
// watchdog that parks the sequencer in ERR after WDOG_CYCLES cycles.
module arc4_ctrl
    import arc4_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    arc4_ctrl_if.slave       host,
    output logic             init_en,
    input  logic             init_rdy,
    output logic             ksa_en,
    input  logic             ksa_rdy,
    output logic             prga_en,
    input  logic             prga_rdy,
    output logic [KEY_W-1:0] eng_key,
    input  logic [7:0]       init_s_addr,
    input  logic [7:0]       init_s_wrdata,
    input  logic             init_s_wren,
    input  logic [7:0]       ksa_s_addr,
    input  logic [7:0]       ksa_s_wrdata,
    input  logic             ksa_s_wren,
    input  logic [7:0]       prga_s_addr,
    input  logic [7:0]       prga_s_wrdata,
    input  logic             prga_s_wren,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren
);

    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [KEY_W-1:0] key_q;
    phase_t           phase;

`ifdef ARC4_CTRL_WDOG_EN
    logic [31:0] wdog_q;

    // True while an engine has been started and has not yet reported done.
    function automatic logic engine_busy(input ctrl_state_t s);
        return (s == INIT_SYNC) || (s == INIT_WAIT) ||
               (s == KSA_SYNC)  || (s == KSA_WAIT)  ||
               (s == PRGA_SYNC) || (s == PRGA_WAIT);
    endfunction

    // Busy counter: restarts with each engine start, counts while it works.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (state_q == INIT_GO || state_q == KSA_GO || state_q == PRGA_GO) begin
            wdog_q <= '0;
        end else if (engine_busy(state_q)) begin
            wdog_q <= wdog_q + 32'd1;
        end
    end
`else
    // The limit only matters when the watchdog is built in.
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
`endif

    // State register (synchronous reset).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Key is captured only on the accepted start; later key changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q <= '0;
        end else if (state_q == IDLE && host.en) begin
            key_q <= host.key;
        end
    end

    // Next-state: GO pulses once, SYNC skips the engine's stale rdy, WAIT
    // advances on rdy (a rdy that never drops counts as instant completion).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (host.en) state_d = INIT_GO;
            INIT_GO:   state_d = INIT_SYNC;
            INIT_SYNC: state_d = INIT_WAIT;
            INIT_WAIT: if (init_rdy) state_d = KSA_GO;
            KSA_GO:    state_d = KSA_SYNC;
            KSA_SYNC:  state_d = KSA_WAIT;
            KSA_WAIT:  if (ksa_rdy) state_d = PRGA_GO;
            PRGA_GO:   state_d = PRGA_SYNC;
            PRGA_SYNC: state_d = PRGA_WAIT;
            PRGA_WAIT: if (prga_rdy) state_d = IDLE;
            ERR:       state_d = ERR;
            default:   state_d = IDLE;
        endcase
`ifdef ARC4_CTRL_WDOG_EN
        if (engine_busy(state_q) && (wdog_q + 32'd1 >= WDOG_CYCLES)) begin
            state_d = ERR;
        end
`endif
    end

    // Outputs decoded from the state register only.
    always_comb begin
        init_en    = (state_q == INIT_GO);
        ksa_en     = (state_q == KSA_GO);
        prga_en    = (state_q == PRGA_GO);
        host.rdy   = (state_q == IDLE);
        phase      = state_phase(state_q);
        host.phase = phase;
`ifdef ARC4_CTRL_WDOG_EN
        host.err   = (state_q == ERR);
`else
        host.err   = 1'b0;
`endif
    end

    assign eng_key = key_q;

    arc4_s_mux u_s_mux (
        .phase         (phase),
        .init_s_addr   (init_s_addr),
        .init_s_wrdata (init_s_wrdata),
        .init_s_wren   (init_s_wren),
        .ksa_s_addr    (ksa_s_addr),
        .ksa_s_wrdata  (ksa_s_wrdata),
        .ksa_s_wren    (ksa_s_wren),
        .prga_s_addr   (prga_s_addr),
        .prga_s_wrdata (prga_s_wrdata),
        .prga_s_wren   (prga_s_wren),
        .s_addr        (s_addr),
        .s_wrdata      (s_wrdata),
        .s_wren        (s_wren)
    );

endmodule

// File: doc/arc4_ctrl.md
Name: arc4_ctrl

Overview:
Top-level sequencer for one ARC4 decryption pass. On a start handshake it runs three engines in order: S-memory init, then KSA, then PRGA. Each engine is driven through its en/rdy handshake. The block owns the single S-memory port and grants it to exactly one engine at a time. It sits between the task-level caller and the init/ksa/prga engines plus the 256x8 S RAM.

Parameters:
WDOG_CYCLES, 4096, max cycles an engine may stay busy before a watchdog error (used only with ARC4_CTRL_WDOG_EN)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  start request; accepted only when rdy=1
rdy  out  1  high when idle and able to accept en
key  in  24  decryption key; sampled on the accepted en
phase  out  2  current S-port owner: 0 idle, 1 init, 2 ksa, 3 prga
init_en  out  1  one-cycle start pulse to init engine
init_rdy  in  1  init engine ready
ksa_en  out  1  one-cycle start pulse to KSA
ksa_rdy  in  1  KSA ready
prga_en  out  1  one-cycle start pulse to PRGA
prga_rdy  in  1  PRGA ready
eng_key  out  24  registered key to KSA/PRGA (key_q)
init_s_addr/init_s_wrdata/init_s_wren  in  8/8/1  init S-port request
ksa_s_addr/ksa_s_wrdata/ksa_s_wren  in  8/8/1  KSA S-port request
prga_s_addr/prga_s_wrdata/prga_s_wren  in  8/8/1  PRGA S-port request
s_addr/s_wrdata/s_wren  out  8/8/1  muxed S RAM port (s_rddata goes straight from RAM to all engines)
err  out  1  watchdog error flag (tied 0 without macro)

Behaviour:
- Reset values: rdy=1, phase=0, all *_en=0, s_addr=0, s_wrdata=0, s_wren=0, eng_key=0, err=0, state=IDLE.
- States: IDLE, INIT_GO, INIT_SYNC, INIT_WAIT, KSA_GO, KSA_SYNC, KSA_WAIT, PRGA_GO, PRGA_SYNC, PRGA_WAIT, ERR.
- IDLE: rdy=1. en=1 -> latch key_q<=key, go to INIT_GO. rdy drops the following cycle.
- X_GO: x_en=1 for exactly one cycle -> X_SYNC.
- X_SYNC: one guard cycle in which x_rdy is ignored, because engines drop rdy one cycle late -> X_WAIT.
- X_WAIT: x_rdy=1 -> next engine's GO state. In PRGA_WAIT, x_rdy=1 -> IDLE.
- Minimum start-to-rdy latency: 9 cycles plus engine busy times.
- phase is decoded from the state register: 1 for INIT_*, 2 for KSA_*, 3 for PRGA_*, 0 for IDLE/ERR.
- S-port mux is combinational on the registered phase, with zero added latency.
- Non-granted engines' wren is never forwarded.
- In phase 0, s_addr, s_wrdata and s_wren are all 0.
- en while rdy=0 is ignored; it is neither queued nor re-latched. key changes after acceptance have no effect.
- Only one *_en is ever high in a cycle. No *_en is high in IDLE or ERR.
- rst_n low mid-operation: next edge returns to IDLE with all outputs at reset values. Engines are reset by the same rst_n.
- x_rdy staying high during X_WAIT with no busy period counts as completion (zero-work engine is legal).

Optional Feature:
ARC4_CTRL_WDOG_EN:
- Defined: a 32-bit busy counter clears on every X_GO and increments in X_SYNC/X_WAIT. Reaching WDOG_CYCLES -> ERR.
- In ERR: err=1, rdy=0, phase=0, S port idle. Only rst_n exits ERR.
- Undefined: no counter, ERR unreachable, err tied 0.

Decomposition:
- Package arc4_pkg: state enum ctrl_state_t; phase_t constants PH_IDLE/PH_INIT/PH_KSA/PH_PRGA; WDOG_CYCLES default; KEY_W=24.
- Sub-module arc4_s_mux: purely combinational 3:1 S-port mux keyed on phase_t, forcing a zero port for PH_IDLE.

Test Plan:
- Stub engines with 3/5/4-cycle busy times; en=1 with key=24'h000018 -> pulse order init, ksa, prga, one cycle each; phase 1,2,3 in sequence; eng_key=24'h000018; rdy back to 1 after 9+3+5+4 cycles.
- en held high through the whole run -> exactly one run per accepted en; key change to 24'hFFFFFF mid-run leaves eng_key unchanged.
- During phase 2, init and prga stubs drive wren=1, addr=8'hAA -> s_wren follows only ksa_s_wren; s_addr equals ksa_s_addr.
- rst_n=0 for one cycle while in KSA_WAIT -> next cycle state IDLE, rdy=1, phase=0, s_wren=0, no en pulses.
- Engine whose rdy never drops -> controller advances after the SYNC cycle with no hang.
- With ARC4_CTRL_WDOG_EN and WDOG_CYCLES=16, ksa_rdy stuck 0 -> err=1 16 cycles after ksa_en; rdy stays 0 until rst_n.
